// File: rtl/alu_seq_if.sv
// Operand/result bundle between the lab CPU datapath and the sequential ALU.
// The master side issues operations, the slave side (the ALU) returns results and SREG.
interface alu_seq_if #(
  parameter int DATA_WIDTH = 8,
  parameter int OPSEL_W    = 4
);
  logic                  start;
  logic [OPSEL_W-1:0]    opsel;
  logic [DATA_WIDTH-1:0] rd;
  logic [DATA_WIDTH-1:0] rr;
  logic [7:0]            flags_in;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] out;
  logic [DATA_WIDTH-1:0] out_hi;
  logic [7:0]            flags_out;

  modport master (
    output start, opsel, rd, rr, flags_in,
    input  busy, done, out, out_hi, flags_out
  );

  modport slave (
    input  start, opsel, rd, rr, flags_in,
    output busy, done, out, out_hi, flags_out
  );
endinterface

// File: rtl/alu_seq.sv
// Registered AVR-style ALU with SREG flag generation and an iterative shift-add MUL.
// Single-cycle ops complete in one edge; MUL holds busy for DATA_WIDTH cycles.
module alu_seq #(
  parameter int DATA_WIDTH = 8,
  parameter int OPSEL_W    = 4
) (
  input logic        clk,
  input logic        rst_n,
  alu_seq_if.slave   bus
);
  localparam int W  = DATA_WIDTH;
  localparam int M  = W - 1;
  localparam int CW = $clog2(W + 1);

  localparam logic [OPSEL_W-1:0] OP_ADD = OPSEL_W'(0);
  localparam logic [OPSEL_W-1:0] OP_ADC = OPSEL_W'(1);
  localparam logic [OPSEL_W-1:0] OP_SUB = OPSEL_W'(2);
  localparam logic [OPSEL_W-1:0] OP_SBC = OPSEL_W'(3);
  localparam logic [OPSEL_W-1:0] OP_AND = OPSEL_W'(4);
  localparam logic [OPSEL_W-1:0] OP_OR  = OPSEL_W'(5);
  localparam logic [OPSEL_W-1:0] OP_EOR = OPSEL_W'(6);
  localparam logic [OPSEL_W-1:0] OP_NEG = OPSEL_W'(7);
  localparam logic [OPSEL_W-1:0] OP_COM = OPSEL_W'(8);
  localparam logic [OPSEL_W-1:0] OP_LSR = OPSEL_W'(9);
  localparam logic [OPSEL_W-1:0] OP_ASR = OPSEL_W'(10);
  localparam logic [OPSEL_W-1:0] OP_ROR = OPSEL_W'(11);
  localparam logic [OPSEL_W-1:0] OP_CP  = OPSEL_W'(12);
  localparam logic [OPSEL_W-1:0] OP_MUL = OPSEL_W'(13);

  typedef enum logic {IDLE, MUL_RUN} state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     out_q, out_d, hi_q, hi_d, mcand_q, mcand_d;
  logic [2*W-1:0]   prod_q, prod_d;
  logic [7:0]       flags_q, flags_d, fl_q, fl_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;

  logic [W-1:0]     rd, rr;
  logic [OPSEL_W-1:0] op;
  logic             cin, zin, hin;

  assign rd  = bus.rd;
  assign rr  = bus.rr;
  assign op  = bus.opsel;
  assign cin = bus.flags_in[0];
  assign zin = bus.flags_in[1];
  assign hin = bus.flags_in[5];

  // Single-cycle datapath
  logic [W-1:0] r_a;
  logic [W:0]   sum_a;
  logic [4:0]   nib_a;
  logic [7:0]   f_a;
  logic         ci_a, c_a, v_a, h_a, n_a, zin_a, keep_a, illegal_a;

  always_comb begin
    r_a       = '0;
    sum_a     = '0;
    nib_a     = '0;
    ci_a      = 1'b0;
    c_a       = cin;
    v_a       = 1'b0;
    h_a       = hin;
    zin_a     = 1'b1;
    keep_a    = 1'b0;
    illegal_a = 1'b0;
    case (op)
      OP_ADD, OP_ADC: begin
        ci_a  = (op == OP_ADC) & cin;
        sum_a = {1'b0, rd} + {1'b0, rr} + {{W{1'b0}}, ci_a};
        nib_a = {1'b0, rd[3:0]} + {1'b0, rr[3:0]} + {4'b0, ci_a};
        r_a   = sum_a[M:0];
        c_a   = sum_a[W];
        h_a   = nib_a[4];
        v_a   = (rd[M] & rr[M] & ~r_a[M]) | (~rd[M] & ~rr[M] & r_a[M]);
      end
      OP_SUB, OP_SBC, OP_CP: begin
        ci_a   = (op == OP_SBC) & cin;
        sum_a  = {1'b0, rd} - {1'b0, rr} - {{W{1'b0}}, ci_a};
        nib_a  = {1'b0, rd[3:0]} - {1'b0, rr[3:0]} - {4'b0, ci_a};
        r_a    = sum_a[M:0];
        c_a    = sum_a[W];
        h_a    = nib_a[4];
        v_a    = (rd[M] & ~rr[M] & ~r_a[M]) | (~rd[M] & rr[M] & r_a[M]);
        zin_a  = (op == OP_SBC) ? zin : 1'b1;
        keep_a = (op == OP_CP);
      end
      OP_AND: r_a = rd & rr;
      OP_OR:  r_a = rd | rr;
      OP_EOR: r_a = rd ^ rr;
      OP_NEG: begin
        r_a = '0 - rd;
        c_a = (r_a != '0);
        v_a = (r_a == {1'b1, {M{1'b0}}});
        h_a = r_a[3] | rd[3];
      end
      OP_COM: begin
        r_a = ~rd;
        c_a = 1'b1;
      end
      OP_LSR, OP_ASR, OP_ROR: begin
        r_a[M-1:0] = rd[M:1];
        r_a[M]     = (op == OP_LSR) ? 1'b0 : (op == OP_ASR) ? rd[M] : cin;
        c_a        = rd[0];
        v_a        = r_a[M] ^ rd[0];
      end
      OP_MUL: ;
      default: illegal_a = 1'b1;
    endcase
    n_a = r_a[M];
    f_a = {bus.flags_in[7:6], h_a, n_a ^ v_a, v_a, n_a, (r_a == '0) & zin_a, c_a};
    if (illegal_a) f_a = bus.flags_in;
  end

  // One shift-add step: conditionally add multiplicand into the high half, shift right
  logic [W:0]     mul_add;
  logic [2*W-1:0] prod_step;
  assign mul_add   = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
  assign prod_step = {mul_add, prod_q[W-1:1]};

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    hi_d    = hi_q;
    flags_d = flags_q;
    mcand_d = mcand_q;
    prod_d  = prod_q;
    fl_d    = fl_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (op == OP_MUL) begin
            state_d = MUL_RUN;
            mcand_d = rd;
            prod_d  = {{W{1'b0}}, rr};
            fl_d    = bus.flags_in;
            cnt_d   = CW'(W);
          end else begin
            out_d   = keep_a ? out_q : r_a;
            hi_d    = keep_a ? hi_q : '0;
            flags_d = f_a;
            done_d  = 1'b1;
          end
        end
      end
      MUL_RUN: begin
        prod_d = prod_step;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          out_d   = prod_step[W-1:0];
          hi_d    = prod_step[2*W-1:W];
          flags_d = {fl_q[7:2], (prod_step == '0), prod_step[2*W-1]};
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      out_q   <= '0;
      hi_q    <= '0;
      flags_q <= '0;
      mcand_q <= '0;
      prod_q  <= '0;
      fl_q    <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      hi_q    <= hi_d;
      flags_q <= flags_d;
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
      fl_q    <= fl_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy      = (state_q == MUL_RUN);
  assign bus.done      = done_q;
  assign bus.out       = out_q;
  assign bus.out_hi    = hi_q;
  assign bus.flags_out = flags_q;
endmodule
